// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants and types for the 8-bit ALU issue controller:
// op codes, instruction classes, FSM states and instruction field positions.
package alu_ctrl_pkg;

  localparam int DATA_W  = 8;
  localparam int RADDR_W = 3;
  localparam int INSTR_W = 19;
  localparam int OP_W    = 4;

  localparam int CLS_HI  = 18;
  localparam int CLS_LO  = 17;
  localparam int OP_HI   = 16;
  localparam int OP_LO   = 14;
  localparam int SHOP_LO = 15;
  localparam int RD_HI   = 13;
  localparam int RD_LO   = 11;
  localparam int RS_HI   = 10;
  localparam int RS_LO   = 8;
  localparam int RT_HI   = 7;
  localparam int RT_LO   = 5;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 0;

  localparam logic [OP_W-1:0] ALU_ADD  = 4'h0;
  localparam logic [OP_W-1:0] ALU_ADC  = 4'h1;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'h2;
  localparam logic [OP_W-1:0] ALU_SBC  = 4'h3;
  localparam logic [OP_W-1:0] ALU_AND  = 4'h4;
  localparam logic [OP_W-1:0] ALU_OR   = 4'h5;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'h6;
  localparam logic [OP_W-1:0] ALU_NAND = 4'h7;
  localparam logic [OP_W-1:0] ALU_SHL  = 4'h8;
  localparam logic [OP_W-1:0] ALU_SHR  = 4'h9;
  localparam logic [OP_W-1:0] ALU_ROL  = 4'hA;
  localparam logic [OP_W-1:0] ALU_ROR  = 4'hB;

  typedef enum logic [1:0] {
    CLS_R   = 2'b00,
    CLS_I   = 2'b01,
    CLS_SH  = 2'b10,
    CLS_ILL = 2'b11
  } cls_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    EXEC = 3'd2,
    WB   = 3'd3,
    ERR  = 3'd4
  } state_e;

  function automatic logic cls_legal(input logic [1:0] cls);
    return cls_e'(cls) != CLS_ILL;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the instruction handshake, register-file and ALU connections
// seen by the issue controller; master is the controller side.
interface alu_issue_ctrl_if import alu_ctrl_pkg::*; ;

  logic                  instr_valid;
  logic [INSTR_W-1:0]    instr;
  logic                  instr_ready;
  logic [RADDR_W-1:0]    rf_ra1;
  logic [RADDR_W-1:0]    rf_ra2;
  logic [DATA_W-1:0]     rf_rd1;
  logic [DATA_W-1:0]     rf_rd2;
  logic                  rf_we;
  logic [RADDR_W-1:0]    rf_wa;
  logic [DATA_W-1:0]     rf_wd;
  logic [INSTR_W-1:0]    alu_instr;
  logic [OP_W-1:0]       alu_op;
  logic [DATA_W-1:0]     alu_a;
  logic [DATA_W-1:0]     alu_b;
  logic                  alu_cin;
  logic [DATA_W-1:0]     alu_y;
  logic                  alu_zero;
  logic                  alu_cout;
  logic                  flag_c;
  logic                  flag_z;
  logic                  done;
  logic                  illegal;

  modport master (
    input  instr_valid, instr, rf_rd1, rf_rd2, alu_y, alu_zero, alu_cout,
    output instr_ready, rf_ra1, rf_ra2, rf_we, rf_wa, rf_wd,
           alu_instr, alu_op, alu_a, alu_b, alu_cin,
           flag_c, flag_z, done, illegal
  );

  modport slave (
    output instr_valid, instr, rf_rd1, rf_rd2, alu_y, alu_zero, alu_cout,
    input  instr_ready, rf_ra1, rf_ra2, rf_we, rf_wa, rf_wd,
           alu_instr, alu_op, alu_a, alu_b, alu_cin,
           flag_c, flag_z, done, illegal
  );

endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational instruction decoder: splits a 19-bit word into ALU op,
// class, register fields, immediate, legality and carry-update qualifier.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output logic [OP_W-1:0]    op_o,
  output cls_e               cls_o,
  output logic [RADDR_W-1:0] rd_o,
  output logic [RADDR_W-1:0] rs_o,
  output logic [RADDR_W-1:0] rt_o,
  output logic [DATA_W-1:0]  imm_o,
  output logic               legal_o,
  output logic               writes_carry_o
);

  always_comb begin
    cls_o          = cls_e'(instr_i[CLS_HI:CLS_LO]);
    rd_o           = instr_i[RD_HI:RD_LO];
    rs_o           = instr_i[RS_HI:RS_LO];
    rt_o           = instr_i[RT_HI:RT_LO];
    imm_o          = instr_i[IMM_HI:IMM_LO];
    op_o           = ALU_ADD;
    legal_o        = 1'b1;
    writes_carry_o = 1'b0;
    case (cls_o)
      CLS_R, CLS_I: begin
        op_o = {1'b0, instr_i[OP_HI:OP_LO]};
        // Only add/adc/sub/sbc produce a meaningful carry-out.
        writes_carry_o = ~instr_i[OP_HI];
      end
      CLS_SH: op_o = {2'b10, instr_i[OP_HI:SHOP_LO]};
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-cycle issue sequencer for the 8-bit ALU: IDLE -> READ -> EXEC -> WB,
// with architectural carry/zero flags and an ERR pulse for illegal words.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  alu_issue_ctrl_if.master  bus
);

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [DATA_W-1:0]    a_q, a_d, b_q, b_d, y_q, y_d;
  logic                 z_q, z_d, cout_q, cout_d;
  logic                 flag_c_q, flag_c_d, flag_z_q, flag_z_d;

  logic [OP_W-1:0]      dec_op;
  cls_e                 dec_cls;
  logic [RADDR_W-1:0]   dec_rd, dec_rs, dec_rt;
  logic [DATA_W-1:0]    dec_imm;
  logic                 dec_legal, dec_wc;

  alu_op_decode u_dec (
    .instr_i        (instr_q),
    .op_o           (dec_op),
    .cls_o          (dec_cls),
    .rd_o           (dec_rd),
    .rs_o           (dec_rs),
    .rt_o           (dec_rt),
    .imm_o          (dec_imm),
    .legal_o        (dec_legal),
    .writes_carry_o (dec_wc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      y_q      <= '0;
      z_q      <= 1'b0;
      cout_q   <= 1'b0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      y_q      <= y_d;
      z_q      <= z_d;
      cout_q   <= cout_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    a_d      = a_q;
    b_d      = b_q;
    y_d      = y_q;
    z_d      = z_q;
    cout_d   = cout_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = cls_legal(bus.instr[CLS_HI:CLS_LO]) ? READ : ERR;
        end
      end
      READ: begin
        a_d = bus.rf_rd1;
        case (dec_cls)
          CLS_R:   b_d = bus.rf_rd2;
          CLS_I:   b_d = dec_imm;
          default: b_d = '0;
        endcase
        state_d = EXEC;
      end
      EXEC: begin
        y_d     = bus.alu_y;
        z_d     = bus.alu_zero;
        cout_d  = bus.alu_cout;
        state_d = WB;
      end
      WB: begin
        // Zero always follows the result, even when rd==0 discards it.
        if (dec_legal) begin
          flag_z_d = z_q;
          if (dec_wc) flag_c_d = cout_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.instr_ready = (state_q == IDLE);
  assign bus.rf_ra1      = (state_q == READ) ? dec_rs : '0;
  assign bus.rf_ra2      = (state_q == READ) ? dec_rt : '0;
  assign bus.rf_we       = (state_q == WB) && (dec_rd != '0);
  assign bus.rf_wa       = (state_q == WB) ? dec_rd : '0;
  assign bus.rf_wd       = (state_q == WB) ? y_q : '0;
  assign bus.alu_instr   = instr_q;
  assign bus.alu_op      = dec_op;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_cin     = flag_c_q;
  assign bus.flag_c      = flag_c_q;
  assign bus.flag_z      = flag_z_q;
  assign bus.done        = (state_q == WB);
  assign bus.illegal     = (state_q == ERR);

endmodule
